// File: rtl/scm_sp_be_init.sv
// Single-port standard-cell memory bank: byte-enabled writes, registered read
// data, post-reset initialisation sweep and out-of-range access flagging.

module scm_sp_be_init_lane #(
   parameter int unsigned NUM_WORDS  = 512,
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]            i_wdata,
   output logic [7:0]            o_rdata
);
   // One byte column of the bank; contents are deliberately never reset.
   logic [7:0] r_mem [NUM_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];
endmodule

module scm_sp_be_init #(
   parameter int unsigned          NUM_WORDS     = 512,
   parameter int unsigned          DATA_WIDTH    = 32,
   parameter int unsigned          ADDR_WIDTH    = $clog2(NUM_WORDS),
   parameter int unsigned          NUM_BYTE      = DATA_WIDTH / 8,
   parameter bit                   INIT_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_cen,
   input  logic                  i_wen,
   input  logic [NUM_BYTE-1:0]   i_be,
   input  logic [ADDR_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q,
   output logic                  o_gnt,
   output logic                  o_init_done,
   output logic                  o_err
);
   typedef enum logic [1:0] {S_RESET, S_INIT, S_READY} state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   r_q;
   logic                    r_init_done;
   logic                    r_err;

   logic                    w_init;
   logic                    w_acc;
   logic                    w_in_range;
   logic                    w_wr;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [NUM_BYTE-1:0][7:0] w_rdata;
   logic [DATA_WIDTH-1:0]   w_rword;

   assign w_init     = (r_state == S_INIT);
   assign w_acc      = (r_state == S_READY) & ~i_cen;
   // Widened compare so non-power-of-two depths flag the unused address tail.
   assign w_in_range = ({1'b0, i_a} < (ADDR_WIDTH+1)'(NUM_WORDS));
   assign w_wr       = w_acc & ~i_wen & w_in_range;
   assign w_addr     = w_init ? r_cnt : i_a;
   assign w_rword    = w_rdata;

   for (genvar g = 0; g < NUM_BYTE; g++) begin : g_lane
      scm_sp_be_init_lane #(
         .NUM_WORDS  (NUM_WORDS),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
         .i_clk   (i_clk),
         .i_we    (w_init | (w_wr & i_be[g])),
         .i_addr  (w_addr),
         .i_wdata (w_init ? INIT_VALUE[8*g +: 8] : i_d[8*g +: 8]),
         .o_rdata (w_rdata[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= S_RESET;
         r_cnt       <= '0;
         r_q         <= '0;
         r_init_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_RESET: begin
               r_cnt <= '0;
               if (INIT_ON_RESET) begin
                  r_state <= S_INIT;
               end else begin
                  r_state     <= S_READY;
                  r_init_done <= 1'b1;
               end
            end
            S_INIT: begin
               if (r_cnt == ADDR_WIDTH'(NUM_WORDS - 1)) begin
                  r_state     <= S_READY;
                  r_init_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READY: begin
               if (w_acc) begin
                  if (!w_in_range) begin
                     r_err <= 1'b1;
                     if (i_wen) r_q <= '0;
                  end else if (i_wen) begin
                     r_q <= w_rword;
                  end
               end
            end
            default: r_state <= S_RESET;
         endcase
      end
   end

   assign o_gnt       = w_acc;
   assign o_q         = r_q;
   assign o_init_done = r_init_done;
   assign o_err       = r_err;
endmodule

// File: tb/tb_scm_sp_be_init.sv
// Directed bench for scm_sp_be_init: three instances cover the 512x32 swept
// bank, a 300-deep bank with address tail, and a 64-bit bank without sweep.

module tb_scm_sp_be_init;
   logic clk;
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 512 x 32, swept with DEADBEEF
   logic        a_rstn, a_cen, a_wen, a_gnt, a_done, a_err, a_gnt_s;
   logic [3:0]  a_be;
   logic [8:0]  a_a;
   logic [31:0] a_d, a_q;
   // Instance B: 300 x 32, swept with 0BADF00D
   logic        b_rstn, b_cen, b_wen, b_gnt, b_done, b_err, b_gnt_s;
   logic [3:0]  b_be;
   logic [8:0]  b_a;
   logic [31:0] b_d, b_q;
   // Instance C: 16 x 64, no sweep
   logic        c_rstn, c_cen, c_wen, c_gnt, c_done, c_err;
   logic [7:0]  c_be;
   logic [3:0]  c_a;
   logic [63:0] c_d, c_q;

   scm_sp_be_init #(.NUM_WORDS(512), .DATA_WIDTH(32), .INIT_ON_RESET(1'b1),
                    .INIT_VALUE(32'hDEAD_BEEF)) u_a (
      .i_clk(clk), .i_rstn(a_rstn), .i_cen(a_cen), .i_wen(a_wen), .i_be(a_be),
      .i_a(a_a), .i_d(a_d), .o_q(a_q), .o_gnt(a_gnt), .o_init_done(a_done),
      .o_err(a_err));

   scm_sp_be_init #(.NUM_WORDS(300), .DATA_WIDTH(32), .INIT_ON_RESET(1'b1),
                    .INIT_VALUE(32'h0BAD_F00D)) u_b (
      .i_clk(clk), .i_rstn(b_rstn), .i_cen(b_cen), .i_wen(b_wen), .i_be(b_be),
      .i_a(b_a), .i_d(b_d), .o_q(b_q), .o_gnt(b_gnt), .o_init_done(b_done),
      .o_err(b_err));

   scm_sp_be_init #(.NUM_WORDS(16), .DATA_WIDTH(64), .INIT_ON_RESET(1'b0)) u_c (
      .i_clk(clk), .i_rstn(c_rstn), .i_cen(c_cen), .i_wen(c_wen), .i_be(c_be),
      .i_a(c_a), .i_d(c_d), .o_q(c_q), .o_gnt(c_gnt), .o_init_done(c_done),
      .o_err(c_err));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic acc_a(input logic cen, input logic wen, input logic [3:0] be,
                        input logic [8:0] a, input logic [31:0] d);
      a_cen = cen; a_wen = wen; a_be = be; a_a = a; a_d = d;
      #1 a_gnt_s = a_gnt;
      tick();
   endtask

   task automatic acc_b(input logic cen, input logic wen, input logic [3:0] be,
                        input logic [8:0] a, input logic [31:0] d);
      b_cen = cen; b_wen = wen; b_be = be; b_a = a; b_d = d;
      #1 b_gnt_s = b_gnt;
      tick();
   endtask

   task automatic acc_c(input logic cen, input logic wen, input logic [7:0] be,
                        input logic [3:0] a, input logic [63:0] d);
      c_cen = cen; c_wen = wen; c_be = be; c_a = a; c_d = d;
      tick();
   endtask

   task automatic test_reset();
      int n, bad;
      a_rstn = 1'b0; a_cen = 1'b0; a_wen = 1'b1; a_a = '0; a_be = '0; a_d = '0;
      repeat (3) tick();
      checks++; if (a_q !== 32'h0) begin failures++; $display("FAIL rst_q got=%h exp=%h", a_q, 32'h0); end
      checks++; if (a_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", a_gnt); end
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", a_done); end
      checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", a_err); end
      a_rstn = 1'b1;
      n = 0; bad = 0;
      while (a_done !== 1'b1 && n < 600) begin
         tick(); n++;
         if (a_gnt !== 1'b0 && a_done !== 1'b1) bad++;
      end
      checks++; if (n != 513) begin failures++; $display("FAIL init_len got=%0d exp=513", n); end
      checks++; if (bad != 0) begin failures++; $display("FAIL init_gnt_low got=%0d exp=0", bad); end
      checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL gnt_after_init got=%b exp=1", a_gnt); end
   endtask

   task automatic test_init_read();
      acc_a(1'b0, 1'b1, 4'h0, 9'd0, 32'h0);
      checks++; if (a_q !== 32'hDEAD_BEEF) begin failures++; $display("FAIL init_w0 got=%h exp=%h", a_q, 32'hDEAD_BEEF); end
      acc_a(1'b0, 1'b1, 4'h0, 9'd511, 32'h0);
      checks++; if (a_q !== 32'hDEAD_BEEF) begin failures++; $display("FAIL init_w511 got=%h exp=%h", a_q, 32'hDEAD_BEEF); end
      checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL init_err got=%b exp=0", a_err); end
   endtask

   task automatic test_byte_enable();
      acc_a(1'b0, 1'b0, 4'hF, 9'd5, 32'h1122_3344);
      acc_a(1'b0, 1'b0, 4'b0101, 9'd5, 32'hAABB_CCDD);
      acc_a(1'b0, 1'b1, 4'h0, 9'd5, 32'h0);
      checks++; if (a_q !== 32'h11BB_33DD) begin failures++; $display("FAIL be_merge got=%h exp=%h", a_q, 32'h11BB_33DD); end
      acc_a(1'b0, 1'b0, 4'h0, 9'd5, 32'hFFFF_FFFF);
      checks++; if (a_gnt_s !== 1'b1) begin failures++; $display("FAIL be0_gnt got=%b exp=1", a_gnt_s); end
      acc_a(1'b0, 1'b1, 4'h0, 9'd5, 32'h0);
      checks++; if (a_q !== 32'h11BB_33DD) begin failures++; $display("FAIL be0_noop got=%h exp=%h", a_q, 32'h11BB_33DD); end
   endtask

   task automatic test_read_after_write();
      acc_a(1'b0, 1'b0, 4'hF, 9'd7, 32'h0000_00A5);
      acc_a(1'b0, 1'b1, 4'h0, 9'd7, 32'h0);
      checks++; if (a_q !== 32'h0000_00A5) begin failures++; $display("FAIL raw got=%h exp=%h", a_q, 32'hA5); end
      for (int i = 0; i < 3; i++) begin
         acc_a(1'b1, 1'b1, 4'h0, 9'd0, 32'h0);
         checks++; if (a_q !== 32'h0000_00A5) begin failures++; $display("FAIL raw_hold%0d got=%h exp=%h", i, a_q, 32'hA5); end
      end
      checks++; if (a_gnt_s !== 1'b0) begin failures++; $display("FAIL idle_gnt got=%b exp=0", a_gnt_s); end
   endtask

   task automatic test_reset_mid_sweep();
      int n, bad;
      a_cen = 1'b1; a_rstn = 1'b0;
      tick();
      checks++; if (a_q !== 32'h0) begin failures++; $display("FAIL ready_rst_q got=%h exp=0", a_q); end
      a_rstn = 1'b1;
      repeat (100) tick();
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", a_done); end
      a_rstn = 1'b0;
      repeat (2) tick();
      a_rstn = 1'b1;
      n = 0;
      while (a_done !== 1'b1 && n < 600) begin tick(); n++; end
      checks++; if (n != 513) begin failures++; $display("FAIL mid_len got=%0d exp=513", n); end
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         acc_a(1'b0, 1'b1, 4'h0, 9'(i), 32'h0);
         if (a_q !== 32'hDEAD_BEEF) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL resweep_words got=%0d bad exp=0", bad); end
   endtask

   task automatic test_out_of_range();
      int n;
      b_rstn = 1'b0; b_cen = 1'b1; b_wen = 1'b1; b_be = '0; b_a = '0; b_d = '0;
      repeat (2) tick();
      b_rstn = 1'b1;
      n = 0;
      while (b_done !== 1'b1 && n < 400) begin tick(); n++; end
      checks++; if (n != 301) begin failures++; $display("FAIL b_init_len got=%0d exp=301", n); end
      acc_b(1'b0, 1'b1, 4'h0, 9'd299, 32'h0);
      checks++; if (b_q !== 32'h0BAD_F00D) begin failures++; $display("FAIL b_w299 got=%h exp=%h", b_q, 32'h0BAD_F00D); end
      acc_b(1'b0, 1'b0, 4'hF, 9'd300, 32'hFFFF_FFFF);
      checks++; if (b_gnt_s !== 1'b1) begin failures++; $display("FAIL oor_gnt got=%b exp=1", b_gnt_s); end
      checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", b_err); end
      checks++; if (b_q !== 32'h0BAD_F00D) begin failures++; $display("FAIL oor_wr_q got=%h exp=%h", b_q, 32'h0BAD_F00D); end
      acc_b(1'b0, 1'b1, 4'h0, 9'd300, 32'h0);
      checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=%b exp=1", b_err); end
      checks++; if (b_q !== 32'h0) begin failures++; $display("FAIL oor_rd_q got=%h exp=0", b_q); end
      acc_b(1'b1, 1'b1, 4'h0, 9'd0, 32'h0);
      checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL oor_err_clr got=%b exp=0", b_err); end
      acc_b(1'b0, 1'b1, 4'h0, 9'd299, 32'h0);
      checks++; if (b_q !== 32'h0BAD_F00D) begin failures++; $display("FAIL b_w299_kept got=%h exp=%h", b_q, 32'h0BAD_F00D); end
      checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL b_inrange_err got=%b exp=0", b_err); end
      acc_b(1'b0, 1'b1, 4'h0, 9'd511, 32'h0);
      checks++; if (b_err !== 1'b1 || b_q !== 32'h0) begin failures++; $display("FAIL oor_511 got=%b/%h exp=1/0", b_err, b_q); end
   endtask

   task automatic test_wide_no_init();
      c_rstn = 1'b0; c_cen = 1'b1; c_wen = 1'b1; c_be = '0; c_a = '0; c_d = '0;
      repeat (2) tick();
      checks++; if (c_done !== 1'b0) begin failures++; $display("FAIL c_rst_done got=%b exp=0", c_done); end
      c_rstn = 1'b1;
      tick();
      checks++; if (c_done !== 1'b1) begin failures++; $display("FAIL c_done got=%b exp=1", c_done); end
      acc_c(1'b0, 1'b0, 8'hFF, 4'd3, 64'h0);
      acc_c(1'b0, 1'b0, 8'hF0, 4'd3, 64'h1122_3344_5566_7788);
      acc_c(1'b0, 1'b1, 8'h00, 4'd3, 64'h0);
      checks++; if (c_q !== 64'h1122_3344_0000_0000) begin failures++; $display("FAIL c_be_hi got=%h exp=%h", c_q, 64'h1122_3344_0000_0000); end
      checks++; if (c_err !== 1'b0) begin failures++; $display("FAIL c_err got=%b exp=0", c_err); end
   endtask

   initial begin
      a_rstn = 1'b0; a_cen = 1'b1; a_wen = 1'b1; a_be = '0; a_a = '0; a_d = '0; a_gnt_s = 1'b0;
      b_rstn = 1'b0; b_cen = 1'b1; b_wen = 1'b1; b_be = '0; b_a = '0; b_d = '0; b_gnt_s = 1'b0;
      c_rstn = 1'b0; c_cen = 1'b1; c_wen = 1'b1; c_be = '0; c_a = '0; c_d = '0;
      tick();
      test_reset();
      test_init_read();
      test_byte_enable();
      test_read_after_write();
      test_reset_mid_sweep();
      test_out_of_range();
      test_wide_no_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/scm_sp_be_init.md
# scm_sp_be_init

Parametrised single-port standard-cell memory bank with byte-enabled writes, registered read data, a hardware initialisation sweep after reset, and out-of-range address detection. It generalises the fixed 512x32 SCM wrapper to arbitrary depth and width. It sits behind the L2/TCDM interconnect as a drop-in memory cut wherever SRAM macros are unavailable or undesirable.

## Interface
- NUM_WORDS, 512: number of words; need not be a power of two.
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, $clog2(NUM_WORDS): address width (derived).
- NUM_BYTE, DATA_WIDTH/8: byte-enable width (derived).
- INIT_ON_RESET, 1: 1 = sweep INIT_VALUE into every word after reset; 0 = no sweep, contents undefined.
- INIT_VALUE, '0: DATA_WIDTH-bit value written during the sweep.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  synchronous active-low reset.
- CEN  in  1  chip enable, active low.
- WEN  in  1  write enable, active low; 1 = read.
- BE  in  NUM_BYTE  byte enables for writes, active high.
- A  in  ADDR_WIDTH  word address.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  registered read data.
- GNT  out  1  request accepted this cycle.
- INIT_DONE  out  1  sweep complete; memory usable.
- ERR  out  1  one-cycle pulse: previous accepted access had A >= NUM_WORDS.

## Operation
- FSM states: RESET, INIT, READY.
- RSTN=0 at an edge enters RESET and sets Q=0, GNT=0, INIT_DONE=0, ERR=0, and init counter=0. Memory contents are not reset.
- RESET→INIT on the first edge with RSTN=1 if INIT_ON_RESET=1. Otherwise RESET→READY.
- INIT: each cycle writes INIT_VALUE (all bytes) to word[counter], then increments counter. After writing word NUM_WORDS-1, go to READY.
- INIT: GNT=0 and requests are ignored. Masters must hold CEN low until GNT.
- READY: GNT = ~CEN, combinational.
- Write (CEN=0, WEN=0, A<NUM_WORDS): byte i of word[A] takes D[8i+7:8i] where BE[i]=1; other bytes are unchanged. BE=0 is a legal no-op that is still granted.
- Read (CEN=0, WEN=1, A<NUM_WORDS): Q is loaded with word[A] at the same edge.
- Out-of-range access (A>=NUM_WORDS, accepted): a write is dropped, a read loads Q=0, and ERR=1 for the following cycle.
- No access, or a refused access: Q holds its last value and ERR=0.
- Reset mid-INIT restarts the sweep from word 0 on release.
- Reset in READY leaves contents intact and, if INIT_ON_RESET=1, re-sweeps.

## Timing
- Read latency is 1 cycle: request at edge n, Q valid after edge n until the next read.
- Write then read of the same address on consecutive cycles returns the new data. A single port means no same-cycle read/write.
- Sweep length: exactly NUM_WORDS cycles. INIT_DONE rises at edge NUM_WORDS+1 after reset release: one edge RESET→INIT, then NUM_WORDS write edges.
- INIT_ON_RESET=0: INIT_DONE=1 after the first edge with RSTN=1.
- GNT is combinational from CEN and the FSM state. Q, INIT_DONE and ERR are registered.
- ERR is asserted for exactly one cycle per offending access. Back-to-back offending accesses keep it high.

## Test plan
- Reset/init, NUM_WORDS=512, INIT_VALUE=32'hDEAD_BEEF, with CEN=0 held from reset release → GNT=0 and INIT_DONE=0 for 513 cycles, then GNT=1. Reading word 0 and word 511 returns 32'hDEAD_BEEF. Q=0 throughout reset.
- Byte enables: write 32'h1122_3344 BE=4'hF to A=5, then 32'hAABB_CCDD BE=4'b0101 to A=5, then read A=5 → Q=32'h11BB_33DD one cycle after the read.
- Read-after-write: write A=7 D=32'h0000_00A5 at cycle n, read A=7 at cycle n+1 → Q=32'h0000_00A5 after edge n+1. Q holds that value through 3 idle cycles.
- Non-power-of-two depth, NUM_WORDS=300 (ADDR_WIDTH=9): write to A=300 then read A=300 → ERR pulses high for one cycle after each access and Q=0. Word 299 is unchanged.
- Reset mid-sweep: assert RSTN=0 at init cycle 100 for 2 cycles → INIT_DONE rises exactly NUM_WORDS+1 edges after release, and all words hold INIT_VALUE.
- INIT_ON_RESET=0, DATA_WIDTH=64, NUM_BYTE=8: INIT_DONE=1 one edge after release. Write a 64-bit word with BE=8'hF0 and read it back → only the upper 32 bits match D.
